dmem_unit: RTL and testbench

Load/store responder for the single-cycle datapath's data-memory port. Takes the ALU result as address, register read-data-2 as store data and the instruction's func3 as access size, and returns load data for the result mux. Contains word-organised data RAM with byte-lane stores, sign/zero-extending loads, and a small MMIO region:

- GPIO output register
- 64-bit free-running cycle counter with atomic high-word snapshot
- sticky misaligned-access fault register

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_ram.sv | 23 ++
 rtl/dmem_unit.sv | 123 ++++++++++++
 tb/tb_dmem_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory unit
// MMIO map and RV32I load/store size encodings.
package dmem_pkg;

   localparam logic [31:0] GPIO_ADDR     = 32'h8000_0000;
   localparam logic [31:0] CYCLE_LO_ADDR = 32'h8000_0004;
   localparam logic [31:0] CYCLE_HI_ADDR = 32'h8000_0008;
   localparam logic [31:0] STATUS_ADDR   = 32'h8000_000C;
   localparam logic [27:0] MMIO_PAGE     = 28'h800_0000;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word-organised data RAM
// Asynchronous read, per-byte-lane synchronous write.
module dmem_ram #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [3:0]               be,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - load/store responder for the single-cycle datapath
// RAM with byte-lane stores, extending loads, GPIO, cycle counter and fault register.
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int GPIO_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              mem_write,
   input  logic              mem_read,
   input  logic [2:0]        func3,
   output logic [31:0]       rdata,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              fault,
   output logic [31:0]       fault_addr
);

   localparam int AW = $clog2(DEPTH);

   logic        is_ram, is_mmio, is_gpio, is_clo, is_chi, is_status;
   logic        legal, aligned, misalign, store_ok, mmio_sw;
   logic [3:0]  lane_be;
   logic [31:0] ram_wdata, ram_rdata, mmio_rdata, src, shifted;
   logic [63:0] cycle;
   logic [31:0] hi_shadow;

   assign is_ram    = addr < 32'(4 * DEPTH);
   assign is_mmio   = addr[31:4] == MMIO_PAGE;
   assign is_gpio   = addr == GPIO_ADDR;
   assign is_clo    = addr == CYCLE_LO_ADDR;
   assign is_chi    = addr == CYCLE_HI_ADDR;
   assign is_status = addr == STATUS_ADDR;

   always_comb begin
      legal     = 1'b1;
      aligned   = 1'b1;
      lane_be   = 4'b0000;
      ram_wdata = wdata;
      case (func3)
         F3_B, F3_BU: begin
            lane_be   = 4'b0001 << addr[1:0];
            ram_wdata = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            aligned   = ~addr[0];
            lane_be   = addr[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{wdata[15:0]}};
         end
         F3_W: begin
            aligned = addr[1:0] == 2'b00;
            lane_be = 4'b1111;
         end
         default: legal = 1'b0;
      endcase
   end

   // Unmapped and illegal-size accesses never fault.
   assign misalign = (mem_read | mem_write) & legal & ~aligned & (is_ram | is_mmio);
   assign store_ok = mem_write & legal & aligned & ~rst;
   assign mmio_sw  = store_ok & (func3 == F3_W);

   dmem_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .idx   (addr[AW+1:2]),
      .be    ((store_ok & is_ram) ? lane_be : 4'b0000),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      mmio_rdata = 32'h0;
      if (is_gpio)   mmio_rdata = 32'(gpio_out);
      if (is_clo)    mmio_rdata = cycle[31:0];
      if (is_chi)    mmio_rdata = hi_shadow;
      if (is_status) mmio_rdata = {31'b0, fault};
   end

   assign src     = is_ram ? ram_rdata : mmio_rdata;
   assign shifted = src >> {addr[1:0], 3'b000};

   always_comb begin
      rdata = 32'h0;
      if (legal && aligned) begin
         case (func3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = src;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_out   <= '0;
         cycle      <= 64'h0;
         hi_shadow  <= 32'h0;
         fault      <= 1'b0;
         fault_addr <= 32'h0;
      end else begin
         cycle <= cycle + 64'd1;
         // A collision counts as a store, so it does not take the snapshot.
         if (mem_read && !mem_write && legal && aligned && is_clo)
            hi_shadow <= cycle[63:32];
         if (mmio_sw && is_gpio)
            gpio_out <= wdata[GPIO_W-1:0];
         if (mmio_sw && is_status) begin
            fault      <= 1'b0;
            fault_addr <= 32'h0;
         end
         if (misalign && !fault) begin
            fault      <= 1'b1;
            fault_addr <= addr;
         end
      end
   end

endmodule

// File: tb/tb_dmem_unit.sv
// tb/tb_dmem_unit.sv - scoreboard bench for dmem_unit
// Driver queues expected load responses; a monitor pops and compares on each load.
module tb_dmem_unit;

   localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
   localparam logic [31:0] GPIO = 32'h8000_0000, CLO = 32'h8000_0004;
   localparam logic [31:0] CHI = 32'h8000_0008, STAT = 32'h8000_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        mem_write = 1'b0, mem_read = 1'b0;
   logic [2:0]  func3 = 3'b010;
   logic [31:0] rdata;
   logic [7:0]  gpio_out;
   logic        fault;
   logic [31:0] fault_addr;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic [7:0]  gp;
      logic        flt;
      logic [31:0] fa;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  m_gpio = 8'h0;
   logic        m_fault = 1'b0;
   logic [31:0] m_faddr = 32'h0;

   dmem_unit #(.DEPTH(1024), .GPIO_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wdata      (wdata),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .func3      (func3),
      .rdata      (rdata),
      .gpio_out   (gpio_out),
      .fault      (fault),
      .fault_addr (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input string what, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s %s got %h expected %h", name, what, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_read && !rst) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_load got addr %h expected no load", addr);
         end else begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "rdata", rdata, e.rd);
            cmp(e.name, "gpio_out", 32'(gpio_out), 32'(e.gp));
            cmp(e.name, "fault", 32'(fault), 32'(e.flt));
            cmp(e.name, "fault_addr", fault_addr, e.fa);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic op(input string name, input bit we, input bit re, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
      exp_t e;
      mem_write = we;
      mem_read  = re;
      func3     = f;
      addr      = a;
      wdata     = d;
      if (re) begin
         e.name = name; e.rd = rd; e.gp = m_gpio; e.flt = m_fault; e.fa = m_faddr;
         q.push_back(e);
      end
      cyc();
      mem_write = 1'b0;
      mem_read  = 1'b0;
   endtask

   task automatic st(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      op("store", 1'b1, 1'b0, f, a, d, 32'h0);
   endtask

   task automatic ld(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
      op(name, 1'b0, 1'b1, f, a, 32'h0, rd);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (5) cyc();
      ld("cycle_after_reset", W, CLO, 32'd5);
      ld("status_reset", W, STAT, 32'h0);

      st(W, 32'h10, 32'hDEAD_BEEF);
      ld("lb_13", B, 32'h13, 32'hFFFF_FFDE);
      ld("lbu_13", BU, 32'h13, 32'h0000_00DE);
      ld("lh_12", H, 32'h12, 32'hFFFF_DEAD);
      ld("lhu_10", HU, 32'h10, 32'h0000_BEEF);
      ld("lw_10", W, 32'h10, 32'hDEAD_BEEF);

      st(W, 32'h20, 32'h1122_3344);
      st(B, 32'h21, 32'h0000_00AA);
      st(H, 32'h22, 32'h0000_5566);
      ld("lane_merge", W, 32'h20, 32'h5566_AA44);
      ld("illegal_f3", 3'b011, 32'h20, 32'h0);

      st(W, 32'h22, 32'hFFFF_FFFF);
      m_fault = 1'b1; m_faddr = 32'h22;
      ld("misaligned_sw_dropped", W, 32'h20, 32'h5566_AA44);
      ld("misaligned_lh", H, 32'h31, 32'h0);
      ld("status_set", W, STAT, 32'h1);
      st(W, STAT, 32'h0);
      m_fault = 1'b0; m_faddr = 32'h0;
      ld("status_cleared", W, STAT, 32'h0);

      op("collision", 1'b1, 1'b1, W, 32'h20, 32'h7777_7777, 32'h5566_AA44);
      ld("after_collision", W, 32'h20, 32'h7777_7777);

      st(W, GPIO, 32'h0000_01A5);
      m_gpio = 8'hA5;
      ld("gpio_rd", W, GPIO, 32'h0000_00A5);
      st(B, GPIO, 32'h0000_0033);
      st(W, CLO, 32'h0);
      ld("gpio_sb_ignored", W, GPIO, 32'h0000_00A5);
      st(W, 32'h4000_0000, 32'hFFFF_FFFF);
      ld("unmapped", W, 32'h4000_0000, 32'h0);
      ld("unmapped_misaligned", W, 32'h4000_0002, 32'h0);
      ld("no_fault_unmapped", W, STAT, 32'h0);

      force dut.cycle = 64'h0000_0000_FFFF_FFFF;
      ld("cycle_lo_wrap", W, CLO, 32'hFFFF_FFFF);
      release dut.cycle;
      cyc();
      ld("cycle_hi_snapshot", W, CHI, 32'h0);

      ld("fault_again", H, 32'h31, 32'h0);
      m_fault = 1'b1; m_faddr = 32'h31;
      st(W, 32'h40, 32'hCAFE_F00D);
      ld("status_before_rst", W, STAT, 32'h1);
      rst = 1'b1;
      mem_write = 1'b1; func3 = W; addr = 32'h40; wdata = 32'h1234_5678;
      cyc();
      mem_write = 1'b0;
      rst = 1'b0;
      m_gpio = 8'h0; m_fault = 1'b0; m_faddr = 32'h0;
      ld("cycle_after_midrst", W, CLO, 32'h0);
      ld("store_in_rst_dropped", W, 32'h40, 32'hCAFE_F00D);

      repeat (3) cyc();
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL pending_loads got %0d expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
